// File: rtl/time_entry_if.sv
// rtl/time_entry_if.sv - keypad/timer-load bus for the microwave time entry block
// Purpose: bundles keypad-side inputs and timer-load outputs of time_entry.
// Signals:
//   key_valid, key_code[3:0]  keypad stroke strobe and value
//   start, cancel, busy       commit request, abort, timer-running flag
//   min_data, sec_tens_data,
//   sec_ones_data [3:0]       M:SS digits presented to the timer load port
//   loadn                     active-low single-cycle load strobe
//   digit_cnt[1:0], err       entry progress and invalid-entry indicator
// Modports: master = keypad/timer side, slave = time_entry.
interface time_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       cancel;
    logic       busy;
    logic [3:0] min_data;
    logic [3:0] sec_tens_data;
    logic [3:0] sec_ones_data;
    logic       loadn;
    logic [1:0] digit_cnt;
    logic       err;

    modport master (
        output key_valid, key_code, start, cancel, busy,
        input  min_data, sec_tens_data, sec_ones_data, loadn, digit_cnt, err
    );

    modport slave (
        input  key_valid, key_code, start, cancel, busy,
        output min_data, sec_tens_data, sec_ones_data, loadn, digit_cnt, err
    );
endinterface

// File: rtl/time_entry.sv
// rtl/time_entry.sv - keypad M:SS collector and timer load strobe generator
// Purpose: shifts decimal keys into a three-digit M:SS buffer, validates it on
//   start and issues a one-cycle active-low load strobe with stable digits.
// Ports:
//   clk    in  system clock, rising edge
//   clrn   in  asynchronous active-low reset
//   bus    time_entry_if.slave (keypad inputs, timer load outputs; all
//          outputs registered)
module time_entry #(
    parameter int MAX_SEC_TENS = 5,
    parameter int ERR_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         clrn,
    time_entry_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_LOAD,
        S_ERR
    } state_t;

    localparam logic [3:0] MAX_TENS = 4'(MAX_SEC_TENS);
    // The entry edge already counts as the first err cycle.
    localparam logic [3:0] ERR_LAST = 4'(ERR_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] cnt_q, cnt_d;
    logic       loadn_q, loadn_d;
    logic       err_q, err_d;
    logic [3:0] ecnt_q, ecnt_d;

    logic valid_digit;
    logic buf_zero;

    assign valid_digit = bus.key_valid & (bus.key_code <= 4'd9) & ~bus.busy;
    assign buf_zero    = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            cnt_q   <= 2'd0;
            loadn_q <= 1'b1;
            err_q   <= 1'b0;
            ecnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            loadn_q <= loadn_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        loadn_d = 1'b1;
        err_d   = 1'b0;
        ecnt_d  = ecnt_q;

        case (state_q)
            S_IDLE: begin
                if (valid_digit) begin
                    min_d   = tens_q;
                    tens_d  = ones_q;
                    ones_d  = bus.key_code;
                    cnt_d   = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (bus.cancel) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end else if (bus.start && !bus.busy) begin
                    // A key arriving together with start is dropped here.
                    if (tens_q > MAX_TENS) begin
                        err_d   = 1'b1;
                        ecnt_d  = ERR_LAST;
                        state_d = S_ERR;
                    end else if (buf_zero) begin
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        loadn_d = 1'b0;
                        state_d = S_LOAD;
                    end
                end else if (valid_digit) begin
                    // Fourth and later digits push the oldest minute value out.
                    min_d  = tens_q;
                    tens_d = ones_q;
                    ones_d = bus.key_code;
                    cnt_d  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                end
            end

            S_LOAD: begin
                // Digits stayed stable through the capture edge; clear now.
                min_d   = 4'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
                cnt_d   = 2'd0;
                state_d = S_IDLE;
            end

            S_ERR: begin
                if (bus.cancel || (ecnt_q == 4'd0)) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    cnt_d   = 2'd0;
                    ecnt_d  = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    err_d  = 1'b1;
                    ecnt_d = ecnt_q - 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.min_data      = min_q;
    assign bus.sec_tens_data = tens_q;
    assign bus.sec_ones_data = ones_q;
    assign bus.loadn         = loadn_q;
    assign bus.digit_cnt     = cnt_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_time_entry.sv
// tb/tb_time_entry.sv - self-checking bench for time_entry
module tb_time_entry;

    localparam int ERRC = 4;
    localparam int MAXT = 5;

    logic clk = 1'b0;
    logic clrn;

    always #5 clk = ~clk;

    time_entry_if bus();

    time_entry #(
        .MAX_SEC_TENS(MAXT),
        .ERR_CYCLES  (ERRC)
    ) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: the buffer is the decimal number typed so far, modulo 1000;
    // mn is how many digits have been taken since the last clear.
    int mv = 0;
    int mn = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_buf(input string tag);
        check({tag, ".min"},  32'(bus.min_data),      32'(mv / 100));
        check({tag, ".tens"}, 32'(bus.sec_tens_data), 32'((mv / 10) % 10));
        check({tag, ".ones"}, 32'(bus.sec_ones_data), 32'(mv % 10));
        check({tag, ".cnt"},  32'(bus.digit_cnt),     32'(mn));
    endtask

    task automatic check_flags(input string tag, input logic exp_loadn, input logic exp_err);
        check({tag, ".loadn"}, 32'(bus.loadn), 32'(exp_loadn));
        check({tag, ".err"},   32'(bus.err),   32'(exp_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input int d);
        mv = (mv * 10 + d) % 1000;
        if (mn < 3) mn++;
    endtask

    task automatic model_clear();
        mv = 0;
        mn = 0;
    endtask

    task automatic press(input logic [3:0] code, input bit b);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        bus.busy      = b;
        cyc();
        bus.key_valid = 1'b0;
        bus.busy      = 1'b0;
        if (code <= 4'd9 && !b) model_push(int'(code));
        check_buf("key");
        check_flags("key", 1'b1, 1'b0);
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        cyc();
        bus.cancel = 1'b0;
        model_clear();
        check_buf("cancel");
        check_flags("cancel", 1'b1, 1'b0);
    endtask

    // Issue start (optionally with busy and/or a simultaneous key) and follow
    // the predicted consequence to completion.
    task automatic do_start(input bit b, input bit with_key, input logic [3:0] code,
                            input bit busy_after);
        bus.start     = 1'b1;
        bus.busy      = b;
        bus.key_valid = with_key;
        bus.key_code  = code;
        cyc();
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.busy      = busy_after;
        if (b || mn == 0) begin
            // Start has no effect; with nothing entered a key is still taken.
            if (with_key && code <= 4'd9 && !b) model_push(int'(code));
            check_buf("nostart");
            check_flags("nostart", 1'b1, 1'b0);
        end else if ((mv / 10) % 10 > MAXT) begin
            check_buf("err_hold");
            check_flags("err_hold", 1'b1, 1'b1);
            for (int i = 1; i < ERRC; i++) begin
                cyc();
                check_buf("err_hold");
                check_flags("err_hold", 1'b1, 1'b1);
            end
            cyc();
            model_clear();
            check_buf("err_exit");
            check_flags("err_exit", 1'b1, 1'b0);
        end else if (mv == 0) begin
            model_clear();
            check_buf("zero_start");
            check_flags("zero_start", 1'b1, 1'b0);
        end else begin
            check_buf("load");
            check_flags("load", 1'b0, 1'b0);
            cyc();
            model_clear();
            check_buf("after_load");
            check_flags("after_load", 1'b1, 1'b0);
        end
        bus.busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.start     = 1'b0;
        bus.cancel    = 1'b0;
        bus.busy      = 1'b0;
        clrn          = 1'b0;
        repeat (3) cyc();
        check_buf("reset");
        check_flags("reset", 1'b1, 1'b0);
        clrn = 1'b1;
        cyc();
        check_buf("post_reset");

        // Plain load 1:30
        press(4'd1, 1'b0); press(4'd3, 1'b0); press(4'd0, 1'b0);
        do_start(1'b0, 1'b0, 4'd0, 1'b0);

        // Illegal seconds tens 2:70
        press(4'd2, 1'b0); press(4'd7, 1'b0); press(4'd0, 1'b0);
        do_start(1'b0, 1'b0, 4'd0, 1'b0);

        // Four digits drop the oldest, busy raised during the load
        press(4'd1, 1'b0); press(4'd2, 1'b0); press(4'd3, 1'b0); press(4'd4, 1'b0);
        do_start(1'b0, 1'b0, 4'd0, 1'b1);

        // Non-digit code ignored, cancel clears
        press(4'd5, 1'b0); press(4'hC, 1'b0);
        do_cancel();

        // Busy blocks keys and start; then 0:09 loads
        press(4'd4, 1'b1); press(4'd5, 1'b1);
        do_start(1'b1, 1'b0, 4'd0, 1'b0);
        press(4'd9, 1'b0);
        do_start(1'b0, 1'b0, 4'd0, 1'b0);

        // Digit coinciding with start is discarded; all-zero entry never loads
        press(4'd4, 1'b0); press(4'd2, 1'b0);
        do_start(1'b0, 1'b1, 4'd7, 1'b0);
        press(4'd0, 1'b0); press(4'd0, 1'b0);
        do_start(1'b0, 1'b0, 4'd0, 1'b0);

        // Cancel exits the error hold early
        press(4'd2, 1'b0); press(4'd8, 1'b0); press(4'd0, 1'b0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check_flags("err_early", 1'b1, 1'b1);
        cyc();
        check_flags("err_early", 1'b1, 1'b1);
        bus.cancel = 1'b1;
        cyc();
        bus.cancel = 1'b0;
        model_clear();
        check_buf("err_cancel");
        check_flags("err_cancel", 1'b1, 1'b0);

        // Reset during the load strobe
        press(4'd1, 1'b0); press(4'd3, 1'b0); press(4'd0, 1'b0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check_flags("rst_load", 1'b0, 1'b0);
        #2;
        clrn = 1'b0;
        #1;
        model_clear();
        check_flags("rst_async", 1'b1, 1'b0);
        check_buf("rst_async");
        cyc();
        clrn = 1'b1;
        do_start(1'b0, 1'b0, 4'd0, 1'b0);
        cyc();
        check_flags("rst_noload", 1'b1, 1'b0);

        // Randomized sessions
        for (int r = 0; r < 40; r++) begin
            int nk;
            nk = $urandom_range(0, 5);
            for (int k = 0; k < nk; k++)
                press(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) < 2) begin
                if (mn > 0) do_cancel();
            end else begin
                do_start(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
